// File: rtl/iod_dly_tap_ctrl_if.sv
// ---------------------------------------------------------------------------
// iod_dly_tap_ctrl_if
//   Command/response bundle between the training or calibration logic and the
//   IOD delay-tap sequencer.
//
//   Command channel (valid/ready):
//     cmd_valid  : command presented by the master
//     cmd_ready  : sequencer idle and able to take a command
//     cmd_lane   : target lane (0 or 1)
//     cmd_op     : 00 load, 01 increment, 10 decrement, 11 reserved (no-op)
//     cmd_steps  : tap steps to move (ignored for load)
//   Response channel (single-cycle, no back-pressure):
//     rsp_valid  : completion pulse
//     rsp_status : 00 OK, 01 CLAMP, 10 OOR
//     rsp_tap    : tap count of the addressed lane after the command
//
//   master : training / calibration side
//   slave  : iod_dly_tap_ctrl
// ---------------------------------------------------------------------------
interface iod_dly_tap_ctrl_if #(
  parameter int TAP_W  = 8,
  parameter int STEP_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_lane;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_steps;
  logic              rsp_valid;
  logic [1:0]        rsp_status;
  logic [TAP_W-1:0]  rsp_tap;

  modport master (
    output cmd_valid, cmd_lane, cmd_op, cmd_steps,
    input  cmd_ready, rsp_valid, rsp_status, rsp_tap
  );

  modport slave (
    input  cmd_valid, cmd_lane, cmd_op, cmd_steps,
    output cmd_ready, rsp_valid, rsp_status, rsp_tap
  );
endinterface

// File: rtl/iod_dly_tap_ctrl.sv
// ---------------------------------------------------------------------------
// iod_dly_tap_ctrl
//   Sequencer for the dynamic delay-line controls of a two-lane IOD pair
//   (e.g. the BG0/BG1 output lanes). Load / increment / decrement commands
//   arrive over a valid/ready handshake; the block emits correctly spaced
//   MOVE, DIRECTION and LOAD pulses to the addressed lane, tracks each lane's
//   tap count, and returns a one-cycle completion response with status
//   OK, CLAMP (tap limit reached) or OOR (IOD flagged out-of-range).
//
// Parameters
//   TAP_W    : width of the per-lane tap counters and rsp_tap
//   STEP_W   : width of cmd_steps
//   MAX_TAP  : highest legal tap value
//   MOVE_GAP : idle cycles after each MOVE or LOAD pulse (legal 1..15)
//
// Ports
//   i_fab_clk                      : fabric clock, rising edge
//   i_sync_rst                     : synchronous active-high reset
//   io_cmd_if                      : command/response bundle (slave side)
//   o_delay_line_move_0/1          : one-cycle tap move pulses
//   o_delay_line_direction_0/1     : 1 = increment, 0 = decrement
//   o_delay_line_load_0/1          : one-cycle tap load (reset) pulses
//   i_delay_line_out_of_range_0/1  : range flags from the IODs
//   o_tap_cnt_0/1                  : current tap count per lane
// ---------------------------------------------------------------------------
module iod_dly_tap_ctrl #(
  parameter int TAP_W    = 8,
  parameter int STEP_W   = 8,
  parameter int MAX_TAP  = 127,
  parameter int MOVE_GAP = 3
) (
  input  logic             i_fab_clk,
  input  logic             i_sync_rst,
  iod_dly_tap_ctrl_if.slave io_cmd_if,
  output logic             o_delay_line_move_0,
  output logic             o_delay_line_move_1,
  output logic             o_delay_line_direction_0,
  output logic             o_delay_line_direction_1,
  output logic             o_delay_line_load_0,
  output logic             o_delay_line_load_1,
  input  logic             i_delay_line_out_of_range_0,
  input  logic             i_delay_line_out_of_range_1,
  output logic [TAP_W-1:0] o_tap_cnt_0,
  output logic [TAP_W-1:0] o_tap_cnt_1
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_CLAMP = 2'b01;
  localparam logic [1:0] ST_OOR   = 2'b10;

  localparam logic [TAP_W-1:0] MAX_TAP_V = TAP_W'(MAX_TAP);
  localparam logic [3:0]       GAP_LAST  = 4'(MOVE_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  // Captured command
  logic              r_lane;
  logic [1:0]        r_op;
  logic [STEP_W-1:0] r_steps;

  logic [3:0]        r_gap_cnt;
  logic [TAP_W-1:0]  r_tap_0;
  logic [TAP_W-1:0]  r_tap_1;
  logic              r_dir_0;
  logic              r_dir_1;

  // Registered pin and response outputs
  logic              r_move_0;
  logic              r_move_1;
  logic              r_load_0;
  logic              r_load_1;
  logic              r_rsp_valid;
  logic [1:0]        r_rsp_status;
  logic [TAP_W-1:0]  r_rsp_tap;

  logic              w_accept;
  logic              w_is_move_op;
  logic              w_lane_eff;
  logic [TAP_W-1:0]  w_tap_sel;
  logic [TAP_W-1:0]  w_tap_eff;
  logic              w_oor_sel;
  logic              w_blocked;
  logic [1:0]        w_status_nxt;

  // True when the next move in the requested direction would leave 0..MAX_TAP.
  function automatic logic f_move_blocked(input logic [1:0]       op,
                                          input logic [TAP_W-1:0] tap);
    return ((op == OP_INC) && (tap == MAX_TAP_V)) ||
           ((op == OP_DEC) && (tap == '0));
  endfunction

  // One-tap step; callers guarantee the result stays in range (no wrap).
  function automatic logic [TAP_W-1:0] f_tap_step(input logic             inc,
                                                  input logic [TAP_W-1:0] tap);
    return inc ? (tap + TAP_W'(1)) : (tap - TAP_W'(1));
  endfunction

  assign io_cmd_if.cmd_ready = (r_state == S_IDLE) && !i_sync_rst;
  assign w_accept     = io_cmd_if.cmd_valid && io_cmd_if.cmd_ready;
  assign w_is_move_op = (io_cmd_if.cmd_op == OP_INC) || (io_cmd_if.cmd_op == OP_DEC);

  // In IDLE the command has not been captured yet, so a reserved op that
  // completes straight from IDLE must report the lane named on the bus.
  assign w_lane_eff = (r_state == S_IDLE) ? io_cmd_if.cmd_lane : r_lane;
  assign w_tap_sel  = r_lane     ? r_tap_1 : r_tap_0;
  assign w_tap_eff  = w_lane_eff ? r_tap_1 : r_tap_0;
  assign w_oor_sel  = r_lane ? i_delay_line_out_of_range_1 : i_delay_line_out_of_range_0;
  assign w_blocked  = f_move_blocked(r_op, w_tap_sel);

  // ---- FSM: state register ----
  always_ff @(posedge i_fab_clk) begin
    if (i_sync_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---- FSM: next state and completion status ----
  always_comb begin
    w_next       = r_state;
    w_status_nxt = ST_OK;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (io_cmd_if.cmd_op)
            OP_LOAD:        w_next = S_LOAD;
            OP_INC, OP_DEC: w_next = S_SETUP;
            default:        w_next = S_DONE;
          endcase
        end
      end
      S_LOAD:  w_next = S_GAP;
      S_SETUP: begin
        if (r_steps == '0) begin
          w_next = S_DONE;
        end else if (w_blocked) begin
          w_next       = S_DONE;
          w_status_nxt = ST_CLAMP;
        end else begin
          w_next = S_PULSE;
        end
      end
      S_PULSE: w_next = S_GAP;
      S_GAP: begin
        // The IOD range flag is only meaningful once the gap has settled,
        // so it is looked at on the last gap cycle only. Taps are not
        // rolled back on OOR: the counter mirrors the pulses actually sent.
        if (r_gap_cnt == GAP_LAST) begin
          if (w_oor_sel) begin
            w_next       = S_DONE;
            w_status_nxt = ST_OOR;
          end else if ((r_op == OP_LOAD) || (r_steps == '0)) begin
            w_next = S_DONE;
          end else if (w_blocked) begin
            w_next       = S_DONE;
            w_status_nxt = ST_CLAMP;
          end else begin
            w_next = S_PULSE;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---- Command capture and step / gap counting ----
  always_ff @(posedge i_fab_clk) begin
    if (w_accept) begin
      r_lane  <= io_cmd_if.cmd_lane;
      r_op    <= io_cmd_if.cmd_op;
      r_steps <= io_cmd_if.cmd_steps;
    end else if (r_state == S_PULSE) begin
      r_steps <= r_steps - STEP_W'(1);
    end

    if (r_state == S_GAP) begin
      r_gap_cnt <= r_gap_cnt + 4'd1;
    end else begin
      r_gap_cnt <= '0;
    end
  end

  // ---- Per-lane tap counters and direction ----
  always_ff @(posedge i_fab_clk) begin
    if (i_sync_rst) begin
      r_tap_0 <= '0;
      r_tap_1 <= '0;
      r_dir_0 <= 1'b0;
      r_dir_1 <= 1'b0;
    end else begin
      // Direction is set at accept so it is already stable in SETUP and
      // well ahead of the first MOVE; it holds until the lane's next command.
      if (w_accept && w_is_move_op) begin
        if (io_cmd_if.cmd_lane) begin
          r_dir_1 <= (io_cmd_if.cmd_op == OP_INC);
        end else begin
          r_dir_0 <= (io_cmd_if.cmd_op == OP_INC);
        end
      end
      if (r_state == S_LOAD) begin
        if (r_lane) begin
          r_tap_1 <= '0;
        end else begin
          r_tap_0 <= '0;
        end
      end else if (r_state == S_PULSE) begin
        if (r_lane) begin
          r_tap_1 <= f_tap_step(r_op == OP_INC, r_tap_1);
        end else begin
          r_tap_0 <= f_tap_step(r_op == OP_INC, r_tap_0);
        end
      end
    end
  end

  // ---- Registered pin pulses and response ----
  // Decoded from the next state so each pulse lines up exactly with the
  // PULSE / LOAD / DONE state it belongs to, without combinational glitches.
  always_ff @(posedge i_fab_clk) begin
    if (i_sync_rst) begin
      r_move_0     <= 1'b0;
      r_move_1     <= 1'b0;
      r_load_0     <= 1'b0;
      r_load_1     <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= ST_OK;
      r_rsp_tap    <= '0;
    end else begin
      r_move_0     <= (w_next == S_PULSE) && !r_lane;
      r_move_1     <= (w_next == S_PULSE) &&  r_lane;
      r_load_0     <= (w_next == S_LOAD)  && !io_cmd_if.cmd_lane;
      r_load_1     <= (w_next == S_LOAD)  &&  io_cmd_if.cmd_lane;
      r_rsp_valid  <= (w_next == S_DONE);
      r_rsp_status <= (w_next == S_DONE) ? w_status_nxt : ST_OK;
      r_rsp_tap    <= (w_next == S_DONE) ? w_tap_eff : '0;
    end
  end

  assign o_delay_line_move_0      = r_move_0;
  assign o_delay_line_move_1      = r_move_1;
  assign o_delay_line_load_0      = r_load_0;
  assign o_delay_line_load_1      = r_load_1;
  assign o_delay_line_direction_0 = r_dir_0;
  assign o_delay_line_direction_1 = r_dir_1;
  assign o_tap_cnt_0              = r_tap_0;
  assign o_tap_cnt_1              = r_tap_1;
  assign io_cmd_if.rsp_valid      = r_rsp_valid;
  assign io_cmd_if.rsp_status     = r_rsp_status;
  assign io_cmd_if.rsp_tap        = r_rsp_tap;

endmodule

// File: tb/tb_iod_dly_tap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iod_dly_tap_ctrl
//   Self-checking bench for iod_dly_tap_ctrl: directed scenarios from the
//   feature list followed by randomized commands checked against a
//   behavioural tap/latency model.
// ---------------------------------------------------------------------------
module tb_iod_dly_tap_ctrl;
  localparam int TAP_W = 8, STEP_W = 8, MAX_TAP = 127, G = 3;
  localparam logic [1:0] OP_LOAD = 2'b00, OP_INC = 2'b01, OP_DEC = 2'b10, OP_RSV = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iod_dly_tap_ctrl_if #(.TAP_W(TAP_W), .STEP_W(STEP_W)) cif ();

  logic mv0, mv1, dir0, dir1, ld0, ld1;
  logic oor0 = 1'b0, oor1 = 1'b0;
  logic [TAP_W-1:0] tap0, tap1;

  iod_dly_tap_ctrl #(.TAP_W(TAP_W), .STEP_W(STEP_W), .MAX_TAP(MAX_TAP), .MOVE_GAP(G)) dut (
    .i_fab_clk                   (clk),
    .i_sync_rst                  (rst),
    .io_cmd_if                   (cif.slave),
    .o_delay_line_move_0         (mv0),
    .o_delay_line_move_1         (mv1),
    .o_delay_line_direction_0    (dir0),
    .o_delay_line_direction_1    (dir1),
    .o_delay_line_load_0         (ld0),
    .o_delay_line_load_1         (ld1),
    .i_delay_line_out_of_range_0 (oor0),
    .i_delay_line_out_of_range_1 (oor1),
    .o_tap_cnt_0                 (tap0),
    .o_tap_cnt_1                 (tap1)
  );

  int n_chk = 0, n_fail = 0;

  // Observations of the last command
  int obs_mv[2], obs_ld[2];
  int obs_ld_rel, obs_rsp_rel, obs_status, obs_rsp_tap;
  int obs_ready_t, obs_busy_ready, obs_multi, obs_dir_rel1;
  int obs_mrel[$];

  // Reference model state
  int m_tap[2];
  int m_dir[2];

  // Outcome of a command computed from the tap rules alone.
  function automatic void predict(input int s, input logic [1:0] op, input int n, input int k,
                                  output int pulses, output int status, output int lat,
                                  output int fin);
    int avail, lim;
    pulses = 0; status = 0; fin = s; lat = 1;
    if (op == OP_LOAD) begin
      fin = 0; lat = 2 + G;
    end else if (op == OP_INC || op == OP_DEC) begin
      avail = (op == OP_INC) ? (MAX_TAP - s) : s;
      lim = (n < avail) ? n : avail;
      if (k >= 1 && k <= lim) begin
        pulses = k; status = 2;
      end else if (n <= avail) begin
        pulses = n; status = 0;
      end else begin
        pulses = avail; status = 1;
      end
      lat = 2 + pulses * (1 + G);
      fin = (op == OP_INC) ? s + pulses : s - pulses;
    end
  endfunction

  // Issue one command and watch the pins until the response (bounded).
  // oor_k > 0 holds the addressed lane's OOR flag high through the gap after
  // pulse k. The other lane's flag, and the addressed flag during pulse
  // cycles, carry random noise that must be ignored.
  task automatic drive_cmd(input logic lane, input logic [1:0] op, input int steps, input int oor_k);
    int lim;
    bit in_gap, pulse_cyc;
    lim = 2 + steps * (1 + G) + 6;
    obs_mv = '{0, 0}; obs_ld = '{0, 0};
    obs_ld_rel = -1; obs_rsp_rel = -1; obs_status = -1; obs_rsp_tap = -1;
    obs_busy_ready = 0; obs_multi = 0; obs_dir_rel1 = -1;
    obs_mrel.delete();
    @(posedge clk); #1;
    cif.cmd_valid = 1'b1;
    cif.cmd_lane  = lane;
    cif.cmd_op    = op;
    cif.cmd_steps = STEP_W'(steps);
    @(negedge clk);
    obs_ready_t = int'(cif.cmd_ready);
    for (int rel = 1; rel <= lim; rel++) begin
      @(posedge clk); #1;
      cif.cmd_valid = 1'b0;
      in_gap    = (oor_k > 0) && (rel > 2 + (oor_k - 1) * (1 + G)) && (rel < 2 + oor_k * (1 + G));
      pulse_cyc = (rel >= 2) && (((rel - 2) % (1 + G)) == 0);
      if (lane) begin
        oor1 = in_gap || (pulse_cyc && ($urandom_range(0, 1) == 1));
        oor0 = ($urandom_range(0, 1) == 1);
      end else begin
        oor0 = in_gap || (pulse_cyc && ($urandom_range(0, 1) == 1));
        oor1 = ($urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      if (rel == 1) obs_dir_rel1 = int'(lane ? dir1 : dir0);
      if (mv0) begin obs_mv[0]++; if (!lane) obs_mrel.push_back(rel); end
      if (mv1) begin obs_mv[1]++; if (lane)  obs_mrel.push_back(rel); end
      if (ld0) begin obs_ld[0]++; obs_ld_rel = rel; end
      if (ld1) begin obs_ld[1]++; obs_ld_rel = rel; end
      if (int'(mv0) + int'(mv1) + int'(ld0) + int'(ld1) > 1) obs_multi++;
      if (cif.cmd_ready) obs_busy_ready++;
      if (cif.rsp_valid) begin
        obs_rsp_rel = rel;
        obs_status  = int'(cif.rsp_status);
        obs_rsp_tap = int'(cif.rsp_tap);
        break;
      end
    end
    oor0 = 1'b0; oor1 = 1'b0;
  endtask

  task automatic test_reset();
    logic [3*TAP_W+9:0] v;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    v = {mv0, mv1, ld0, ld1, dir0, dir1, tap0, tap1, cif.rsp_valid, cif.rsp_status, cif.rsp_tap};
    n_chk++; if (v !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h required 0", v); end
    n_chk++; if (cif.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", cif.cmd_ready); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_chk++; if (cif.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b required 1", cif.cmd_ready); end
  endtask

  task automatic test_inc_basic();
    int bad;
    drive_cmd(1'b0, OP_INC, 3, 0);
    bad = (obs_mrel.size() != 3) ? 1 : 0;
    if (bad == 0 && (obs_mrel[0] != 2 || obs_mrel[1] != 6 || obs_mrel[2] != 10)) bad = 1;
    n_chk++; if (obs_ready_t !== 1) begin n_fail++; $display("FAIL inc_accept_ready: got %0d required 1", obs_ready_t); end
    n_chk++; if (obs_dir_rel1 !== 1) begin n_fail++; $display("FAIL inc_dir_t1: got %0d required 1", obs_dir_rel1); end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL inc_pulse_times: got %0d pulses required 3 at t+2,t+6,t+10", obs_mrel.size()); end
    n_chk++; if (obs_rsp_rel !== 14) begin n_fail++; $display("FAIL inc_rsp_latency: got %0d required 14", obs_rsp_rel); end
    n_chk++; if (obs_status !== 0 || obs_rsp_tap !== 3) begin n_fail++; $display("FAIL inc_rsp: got status %0d tap %0d required 0/3", obs_status, obs_rsp_tap); end
    n_chk++; if (tap0 !== 8'd3) begin n_fail++; $display("FAIL inc_tap0: got %0d required 3", tap0); end
    n_chk++; if (obs_mv[1] !== 0 || obs_ld[1] !== 0 || dir1 !== 1'b0 || tap1 !== '0) begin n_fail++; $display("FAIL inc_lane1_quiet: got moves %0d loads %0d dir %b tap %0d required all 0", obs_mv[1], obs_ld[1], dir1, tap1); end
  endtask

  task automatic test_clamp();
    drive_cmd(1'b1, OP_INC, 125, 0);
    n_chk++; if (tap1 !== 8'd125) begin n_fail++; $display("FAIL clamp_preload: got %0d required 125", tap1); end
    drive_cmd(1'b1, OP_INC, 5, 0);
    n_chk++; if (obs_mv[1] !== 2) begin n_fail++; $display("FAIL clamp_pulses: got %0d required 2", obs_mv[1]); end
    n_chk++; if (obs_status !== 1 || obs_rsp_tap !== 127) begin n_fail++; $display("FAIL clamp_rsp: got status %0d tap %0d required 1/127", obs_status, obs_rsp_tap); end
    n_chk++; if (obs_rsp_rel !== 10 || tap1 !== 8'd127) begin n_fail++; $display("FAIL clamp_timing: got rsp t+%0d tap %0d required t+10/127", obs_rsp_rel, tap1); end
  endtask

  task automatic test_oor();
    drive_cmd(1'b0, OP_INC, 7, 0);
    drive_cmd(1'b0, OP_DEC, 4, 2);
    n_chk++; if (obs_mv[0] !== 2) begin n_fail++; $display("FAIL oor_pulses: got %0d required 2", obs_mv[0]); end
    n_chk++; if (obs_status !== 2 || obs_rsp_rel !== 10) begin n_fail++; $display("FAIL oor_rsp: got status %0d at t+%0d required 2 at t+10", obs_status, obs_rsp_rel); end
    n_chk++; if (tap0 !== 8'd8 || obs_rsp_tap !== 8 || dir0 !== 1'b0) begin n_fail++; $display("FAIL oor_tap: got tap %0d rsp_tap %0d dir %b required 8/8/0", tap0, obs_rsp_tap, dir0); end
  endtask

  task automatic test_load();
    drive_cmd(1'b1, OP_LOAD, 0, 0);
    drive_cmd(1'b1, OP_INC, 10, 0);
    n_chk++; if (tap1 !== 8'd10) begin n_fail++; $display("FAIL load_preload: got %0d required 10", tap1); end
    drive_cmd(1'b1, OP_LOAD, $urandom_range(0, 255), 0);
    n_chk++; if (obs_ld[1] !== 1 || obs_ld_rel !== 1 || obs_ld[0] !== 0) begin n_fail++; $display("FAIL load_pulse: got %0d pulses last at t+%0d required one at t+1", obs_ld[1] + obs_ld[0], obs_ld_rel); end
    n_chk++; if (obs_rsp_rel !== 5 || obs_status !== 0) begin n_fail++; $display("FAIL load_rsp: got t+%0d status %0d required t+5/0", obs_rsp_rel, obs_status); end
    n_chk++; if (tap1 !== '0 || obs_busy_ready !== 0 || obs_mv[1] !== 0) begin n_fail++; $display("FAIL load_state: got tap %0d ready_cycles %0d moves %0d required 0/0/0", tap1, obs_busy_ready, obs_mv[1]); end
    n_chk++; if (dir1 !== 1'b1) begin n_fail++; $display("FAIL load_dir_hold: got %b required 1", dir1); end
  endtask

  task automatic test_zero_and_reserved();
    drive_cmd(1'b0, OP_INC, 0, 0);
    n_chk++; if (obs_rsp_rel !== 2 || obs_status !== 0 || obs_mv[0] !== 0 || obs_rsp_tap !== 8) begin n_fail++; $display("FAIL zero_inc: got t+%0d status %0d moves %0d tap %0d required t+2/0/0/8", obs_rsp_rel, obs_status, obs_mv[0], obs_rsp_tap); end
    n_chk++; if (dir0 !== 1'b1) begin n_fail++; $display("FAIL zero_inc_dir: got %b required 1", dir0); end
    drive_cmd(1'b0, OP_RSV, 9, 0);
    n_chk++; if (obs_rsp_rel !== 1 || obs_status !== 0 || obs_mv[0] + obs_ld[0] !== 0 || obs_rsp_tap !== 8) begin n_fail++; $display("FAIL reserved_op: got t+%0d status %0d activity %0d tap %0d required t+1/0/0/8", obs_rsp_rel, obs_status, obs_mv[0] + obs_ld[0], obs_rsp_tap); end
    drive_cmd(1'b1, OP_DEC, 3, 0);
    n_chk++; if (obs_rsp_rel !== 2 || obs_status !== 1 || obs_mv[1] !== 0 || tap1 !== '0) begin n_fail++; $display("FAIL dec_at_zero: got t+%0d status %0d moves %0d tap %0d required t+2/1/0/0", obs_rsp_rel, obs_status, obs_mv[1], tap1); end
  endtask

  task automatic test_reset_mid();
    int pre_mv = 0, post_mv = 0, post_rsp = 0;
    logic [3*TAP_W+9:0] v;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b1; cif.cmd_lane = 1'b0; cif.cmd_op = OP_INC; cif.cmd_steps = 8'd4;
    for (int rel = 1; rel <= 4; rel++) begin
      @(posedge clk); #1;
      cif.cmd_valid = 1'b0;
      if (rel == 4) rst = 1'b1;
      @(negedge clk);
      if (mv0) pre_mv++;
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    v = {mv0, mv1, ld0, ld1, dir0, dir1, tap0, tap1, cif.rsp_valid, cif.rsp_status, cif.rsp_tap};
    n_chk++; if (pre_mv !== 1) begin n_fail++; $display("FAIL rstmid_first_pulse: got %0d required 1", pre_mv); end
    n_chk++; if (cif.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b required 1", cif.cmd_ready); end
    n_chk++; if (v !== '0) begin n_fail++; $display("FAIL rstmid_outputs: got %h required 0", v); end
    repeat (20) begin
      @(negedge clk);
      if (mv0 || mv1) post_mv++;
      if (cif.rsp_valid) post_rsp++;
    end
    n_chk++; if (post_mv !== 0 || post_rsp !== 0) begin n_fail++; $display("FAIL rstmid_quiet: got moves %0d rsp %0d required 0/0", post_mv, post_rsp); end
  endtask

  task automatic test_random();
    logic lane;
    logic [1:0] op;
    int r, steps, k, pulses, st, lat, fin, bad;
    m_tap = '{0, 0};
    m_dir = '{0, 0};
    for (int i = 0; i < 40; i++) begin
      lane = logic'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      op = (r == 0) ? OP_LOAD : (r == 1) ? OP_RSV : (r < 6) ? OP_INC : OP_DEC;
      steps = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 160) : $urandom_range(0, 10);
      k = (op != OP_LOAD && op != OP_RSV && $urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      predict(m_tap[lane], op, steps, k, pulses, st, lat, fin);
      drive_cmd(lane, op, steps, k);
      bad = (obs_mrel.size() != pulses) ? 1 : 0;
      for (int p = 0; p < obs_mrel.size() && bad == 0; p++)
        if (obs_mrel[p] != 2 + p * (1 + G)) bad = 1;
      n_chk++; if (obs_ready_t !== 1) begin n_fail++; $display("FAIL rnd%0d_ready: got %0d required 1", i, obs_ready_t); end
      n_chk++; if (obs_rsp_rel !== lat) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d required %0d", i, obs_rsp_rel, lat); end
      n_chk++; if (obs_status !== st) begin n_fail++; $display("FAIL rnd%0d_status: got %0d required %0d", i, obs_status, st); end
      n_chk++; if (obs_rsp_tap !== fin) begin n_fail++; $display("FAIL rnd%0d_rsp_tap: got %0d required %0d", i, obs_rsp_tap, fin); end
      n_chk++; if (bad !== 0 || obs_mv[!lane] !== 0) begin n_fail++; $display("FAIL rnd%0d_pulses: got %0d/%0d required %0d on lane %0d", i, obs_mv[lane], obs_mv[!lane], pulses, lane); end
      n_chk++; if (obs_ld[lane] !== ((op == OP_LOAD) ? 1 : 0) || obs_ld[!lane] !== 0) begin n_fail++; $display("FAIL rnd%0d_loads: got %0d required %0d", i, obs_ld[lane] + obs_ld[!lane], (op == OP_LOAD) ? 1 : 0); end
      n_chk++; if (obs_busy_ready !== 0 || obs_multi !== 0) begin n_fail++; $display("FAIL rnd%0d_excl: got ready_cycles %0d overlaps %0d required 0/0", i, obs_busy_ready, obs_multi); end
      m_tap[lane] = fin;
      if (op == OP_INC || op == OP_DEC) m_dir[lane] = (op == OP_INC) ? 1 : 0;
      n_chk++; if (int'(tap0) !== m_tap[0] || int'(tap1) !== m_tap[1]) begin n_fail++; $display("FAIL rnd%0d_taps: got %0d/%0d required %0d/%0d", i, tap0, tap1, m_tap[0], m_tap[1]); end
      n_chk++; if (int'(dir0) !== m_dir[0] || int'(dir1) !== m_dir[1]) begin n_fail++; $display("FAIL rnd%0d_dirs: got %b/%b required %0d/%0d", i, dir0, dir1, m_dir[0], m_dir[1]); end
    end
  endtask

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_lane  = 1'b0;
    cif.cmd_op    = 2'b00;
    cif.cmd_steps = '0;
    test_reset();
    test_inc_basic();
    test_clamp();
    test_oor();
    test_load();
    test_zero_and_reserved();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
